// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button conditioner.
//   state_t            : per-channel debounce FSM state (IDLE, WAIT_HI, HIGH, WAIT_LO)
//   CH_START/STOP/CLEAR: channel indices for the three front-panel buttons
// No ports (package).
// -----------------------------------------------------------------------------
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      HIGH    = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   localparam int CH_START = 0;
   localparam int CH_STOP  = 1;
   localparam int CH_CLEAR = 2;

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
// Bundles the button-side signals of button_conditioner.
//   btn_raw   : raw bouncing button levels (driven by master)
//   btn_level : debounced levels
//   btn_rise  : one-cycle accepted-press pulses
//   btn_fall  : one-cycle accepted-release pulses
//   btn_long  : one-cycle long-press pulses (only with BTN_LONG_PRESS_EN)
//   dbg_state : per-channel FSM state, for observation
// Handshake: there is no valid/ready pair; btn_rise/btn_fall/btn_long act as
// one-cycle "valid" strobes that the consumer must take in the cycle they are
// high (no back-pressure).
// Modports: master = button/consumer side, slave = conditioner side.
// Macro: BTN_LONG_PRESS_EN adds btn_long.
// -----------------------------------------------------------------------------
interface button_conditioner_if #(
   parameter int N = 3
);
   import btn_pkg::*;

   logic [N-1:0]   btn_raw;
   logic [N-1:0]   btn_level;
   logic [N-1:0]   btn_rise;
   logic [N-1:0]   btn_fall;
`ifdef BTN_LONG_PRESS_EN
   logic [N-1:0]   btn_long;
`endif
   state_t [N-1:0] dbg_state;

`ifdef BTN_LONG_PRESS_EN
   modport master (output btn_raw, input btn_level, input btn_rise, input btn_fall,
                   input btn_long, input dbg_state);
   modport slave  (input btn_raw, output btn_level, output btn_rise, output btn_fall,
                   output btn_long, output dbg_state);
`else
   modport master (output btn_raw, input btn_level, input btn_rise, input btn_fall,
                   input dbg_state);
   modport slave  (input btn_raw, output btn_level, output btn_rise, output btn_fall,
                   output dbg_state);
`endif

endinterface

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One button channel: 2-flop synchronizer, 4-state debounce FSM with a
// saturating stability counter, registered rise/fall pulses and, with
// BTN_LONG_PRESS_EN, a hold counter producing one long-press pulse.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   raw_i      : asynchronous raw button level
//   level_o    : debounced level
//   rise_o     : one-cycle pulse in the first HIGH cycle
//   fall_o     : one-cycle pulse in the first IDLE cycle after release
//   long_o     : one-cycle long-press pulse (only with BTN_LONG_PRESS_EN)
//   state_o    : current FSM state
// -----------------------------------------------------------------------------
module debounce_ch
   import btn_pkg::*;
#(
   parameter int DB_CYCLES   = 1_000_000,
   parameter int HOLD_CYCLES = 100_000_000
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   raw_i,
   output logic   level_o,
   output logic   rise_o,
   output logic   fall_o,
`ifdef BTN_LONG_PRESS_EN
   output logic   long_o,
`endif
   output state_t state_o
);

   localparam int            CW       = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   logic          sync1_q, sync2_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Synchronizer: only sync2_q is used by the FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = WAIT_HI;
               cnt_d   = '0;
            end
         end
         WAIT_HI: begin
            if (!sync2_q) begin
               state_d = IDLE;
            end else begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = HIGH;
                  rise_d  = 1'b1;
               end
            end
         end
         HIGH: begin
            if (!sync2_q) begin
               state_d = WAIT_LO;
               cnt_d   = '0;
            end
         end
         WAIT_LO: begin
            if (sync2_q) begin
               // Bounce during release: back to HIGH silently.
               state_d = HIGH;
            end else begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = IDLE;
                  fall_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Level follows the accepted state, so it stays high through WAIT_LO.
   assign level_o = (state_q == HIGH) || (state_q == WAIT_LO);
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign state_o = state_q;

`ifdef BTN_LONG_PRESS_EN
   localparam int            HW        = $clog2(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   logic [HW-1:0] hold_q, hold_d;
   logic          long_q, long_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   // Hold counter runs only in HIGH and sticks at HOLD_LAST, so the pulse
   // fires once per press.
   always_comb begin
      hold_d = '0;
      long_d = 1'b0;
      if (state_q == HIGH) begin
         hold_d = hold_q;
         if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_d == HOLD_LAST);
         end
      end
   end

   assign long_o = long_q;
`endif

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// N independent debounced push-button channels (ch0 start, ch1 stop,
// ch2 clear), each a debounce_ch instance.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous active-high reset, priority over all inputs
//   bus   : button_conditioner_if.slave (btn_raw in; btn_level, btn_rise,
//           btn_fall, [btn_long], dbg_state out)
// Macro: BTN_LONG_PRESS_EN enables btn_long and the hold counters.
// -----------------------------------------------------------------------------
module button_conditioner
   import btn_pkg::*;
#(
   parameter int N           = 3,
   parameter int DB_CYCLES   = 1_000_000,
   parameter int HOLD_CYCLES = 100_000_000
) (
   input  logic                   clk,
   input  logic                   reset,
   button_conditioner_if.slave    bus
);

   for (genvar i = 0; i < N; i++) begin : g_ch
      debounce_ch #(
         .DB_CYCLES   (DB_CYCLES),
         .HOLD_CYCLES (HOLD_CYCLES)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .raw_i   (bus.btn_raw[i]),
         .level_o (bus.btn_level[i]),
         .rise_o  (bus.btn_rise[i]),
         .fall_o  (bus.btn_fall[i]),
`ifdef BTN_LONG_PRESS_EN
         .long_o  (bus.btn_long[i]),
`endif
         .state_o (bus.dbg_state[i])
      );
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N, default 3: number of button channels (ch0 start, ch1 stop, ch2 clear).
REQ-002 Parameter DB_CYCLES, default 1_000_000: stable cycles required to accept a level change (10 ms at 100 MHz); legal range 2 to 2^24.
REQ-003 Parameter HOLD_CYCLES, default 100_000_000: cycles of continuous accepted press that qualify as a long press.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Port btn_raw, input, N bits: asynchronous, bouncing push-button levels, active high.
REQ-007 Port btn_level, output, N bits: debounced level per channel.
REQ-008 Port btn_rise, output, N bits: one-cycle pulse per channel when an accepted press occurs.
REQ-009 Port btn_fall, output, N bits: one-cycle pulse per channel when an accepted release occurs.
REQ-010 Port btn_long, output, N bits: one-cycle long-press pulse per channel; exists only when the macro in REQ-025 is defined.

Function
REQ-011 Each channel SHALL pass btn_raw through a 2-flop synchronizer; only the second flop output (sync) feeds the FSM.
REQ-012 Each channel SHALL run a 4-state FSM: IDLE, WAIT_HI, HIGH and WAIT_LO, with a per-channel counter of width $clog2(DB_CYCLES).
REQ-013 IDLE: btn_level=0; sync=1 -> WAIT_HI with the counter cleared.
REQ-014 WAIT_HI: btn_level=0; sync=0 -> IDLE; otherwise the counter increments; counter==DB_CYCLES-1 with sync=1 -> HIGH, and btn_rise=1 in the first HIGH cycle.
REQ-015 HIGH: btn_level=1; sync=0 -> WAIT_LO with the counter cleared.
REQ-016 WAIT_LO: btn_level=1; sync=1 -> HIGH with no pulse; otherwise the counter increments; counter==DB_CYCLES-1 with sync=0 -> IDLE, and btn_fall=1 in the first IDLE cycle.
REQ-017 Latency: raw held high from clock edge k SHALL produce btn_rise high in exactly the cycle after edge k+DB_CYCLES+2; release latency is identical.
REQ-018 A glitch shorter than DB_CYCLES cycles SHALL produce no pulse and no btn_level change.
REQ-019 btn_rise and btn_fall SHALL each be high for exactly one cycle per accepted transition and never high together on the same channel.
REQ-020 Channels SHALL be fully independent; simultaneous presses on several channels SHALL pulse in the same cycle.
REQ-021 The counter SHALL saturate and never wrap.

Reset
REQ-022 Reset SHALL force every FSM to IDLE, clear all counters and synchronizer flops, and drive btn_level, btn_rise, btn_fall and btn_long to 0 in the following cycle.
REQ-023 Reset asserted mid-debounce or mid-press SHALL discard all progress; a button still held after reset SHALL require a full DB_CYCLES+2 cycles to produce btn_rise.
REQ-024 Reset SHALL take priority over all inputs.

Configuration
REQ-025 Macro BTN_LONG_PRESS_EN controls the long-press feature.
- Defined: a per-channel hold counter SHALL run while in HIGH and clear otherwise; btn_long SHALL pulse once when it reaches HOLD_CYCLES-1, then saturate until release.
- Not defined: the btn_long port, the hold counter and HOLD_CYCLES logic SHALL be absent.

Structure
REQ-026 Package btn_pkg SHALL hold the state enum typedef (IDLE, WAIT_HI, HIGH, WAIT_LO) and the channel index constants CH_START=0, CH_STOP=1, CH_CLEAR=2.
REQ-027 The single-channel logic (synchronizer, FSM, counters) SHALL be sub-module debounce_ch, instantiated N times in a generate loop by button_conditioner.

Verification (DB_CYCLES=4, HOLD_CYCLES=10)
REQ-028 Raw ch0 rises at edge 10 and is held -> btn_rise[0] high only in the cycle after edge 16; btn_level[0]=1 from then on.
REQ-029 Raw ch1 pulses high for 3 cycles -> btn_rise[1], btn_fall[1] and btn_level[1] remain 0 throughout.
REQ-030 Ch0 accepted press, then raw low for 2 cycles and high again -> no btn_fall, btn_level[0] stays 1.
REQ-031 Ch0 and ch2 raw rise on the same edge -> btn_rise[0] and btn_rise[2] pulse in the same cycle.
REQ-032 Reset asserted 2 cycles into WAIT_HI with raw held -> all outputs 0, then btn_rise exactly 6 cycles after reset deasserts.
REQ-033 With BTN_LONG_PRESS_EN defined, hold ch1 for 20 cycles after btn_rise -> exactly one btn_long[1] pulse, 9 cycles after btn_rise.
